// File: rtl/vx_avs_slave_bridge_pkg.sv
// ---------------------------------------------------------------------------
// vx_avs_slave_bridge_pkg
//
// Shared definitions for the Avalon-MM slave bridge:
//   - avs_slave_state_t : command FSM state encoding
//   - calc_tag_width()  : derives the ROB tag width from the queue depth
// ---------------------------------------------------------------------------
package vx_avs_slave_bridge_pkg;

    typedef enum logic [1:0] {
        AVS_IDLE     = 2'd0,
        AVS_RD_BURST = 2'd1,
        AVS_WR_BURST = 2'd2
    } avs_slave_state_t;

    // A single-entry queue still needs a one-bit tag so that ports stay legal.
    function automatic int calc_tag_width(input int queue_size);
        return (queue_size > 1) ? $clog2(queue_size) : 1;
    endfunction

endpackage

// File: rtl/vx_avs_slave_bridge_if.sv
// ---------------------------------------------------------------------------
// vx_avs_slave_bridge_if
//
// Bundles the Avalon-MM slave port and the native memory request/response
// port of the bridge.
//   modport slave  : the bridge's view (AVS command in, mem request out,
//                    mem response in)
//   modport master : the environment's view (external Avalon master plus
//                    the memory agent)
// ---------------------------------------------------------------------------
interface vx_avs_slave_bridge_if #(
    parameter int DATA_WIDTH  = 512,
    parameter int ADDR_WIDTH  = 26,
    parameter int BURST_WIDTH = 4,
    parameter int TAG_WIDTH   = 4
);

    // Avalon-MM slave side
    logic [ADDR_WIDTH-1:0]     avs_address;
    logic                      avs_read;
    logic                      avs_write;
    logic [DATA_WIDTH-1:0]     avs_writedata;
    logic [DATA_WIDTH/8-1:0]   avs_byteenable;
    logic [BURST_WIDTH-1:0]    avs_burstcount;
    logic                      avs_waitrequest;
    logic [DATA_WIDTH-1:0]     avs_readdata;
    logic                      avs_readdatavalid;

    // Native memory request
    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic                      mem_req_rw;
    logic [DATA_WIDTH/8-1:0]   mem_req_byteen;
    logic [ADDR_WIDTH-1:0]     mem_req_addr;
    logic [DATA_WIDTH-1:0]     mem_req_data;
    logic [TAG_WIDTH-1:0]      mem_req_tag;

    // Native memory response
    logic                      mem_rsp_valid;
    logic [DATA_WIDTH-1:0]     mem_rsp_data;
    logic [TAG_WIDTH-1:0]      mem_rsp_tag;
    logic                      mem_rsp_ready;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
               avs_byteenable, avs_burstcount,
        output avs_waitrequest, avs_readdata, avs_readdatavalid,
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
               mem_req_data, mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output mem_rsp_ready
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
               avs_byteenable, avs_burstcount,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid,
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
               mem_req_data, mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  mem_rsp_ready
    );

endinterface

// File: rtl/vx_avs_slave_bridge_rob.sv
// ---------------------------------------------------------------------------
// vx_avs_rob
//
// Read reorder buffer. Slots are allocated in command order, filled in any
// order by tagged memory responses, and drained strictly in allocation
// order onto a registered output.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   alloc                 reserve the slot at alloc_tag (must not be full)
//   alloc_tag             current allocation pointer = tag for next read
//   full                  all QUEUE_SIZE slots reserved
//   rsp_valid/tag/data    memory response filling slot rsp_tag
//   out_valid/out_data    in-order drained beat (registered)
// ---------------------------------------------------------------------------
module vx_avs_rob #(
    parameter int DATA_WIDTH = 512,
    parameter int QUEUE_SIZE = 16,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alloc,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    output logic                  full,
    input  logic                  rsp_valid,
    input  logic [TAG_WIDTH-1:0]  rsp_tag,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int CNT_WIDTH = $clog2(QUEUE_SIZE + 1);

    logic [DATA_WIDTH-1:0] data_mem [QUEUE_SIZE];
    logic [QUEUE_SIZE-1:0] slot_valid;
    logic [TAG_WIDTH-1:0]  wr_ptr;
    logic [TAG_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  occupancy;

    logic [TAG_WIDTH-1:0]  rsp_offset;
    logic                  rsp_allocated;
    logic                  rsp_accept;
    logic                  head_bypass;
    logic                  drain;
    logic [DATA_WIDTH-1:0] head_data;

    // A slot is live when its distance from the head is below the occupancy.
    // Responses to dead slots (e.g. stragglers from before a reset) are
    // dropped rather than corrupting state.
    assign rsp_offset    = rsp_tag - rd_ptr;
    assign rsp_allocated = CNT_WIDTH'(rsp_offset) < occupancy;
    assign rsp_accept    = rsp_valid && rsp_allocated && !slot_valid[rsp_tag];

    // A response for the head slot is forwarded straight to the output
    // register, giving single-cycle response-to-readdatavalid latency.
    assign head_bypass = rsp_accept && (rsp_tag == rd_ptr);
    assign drain       = slot_valid[rd_ptr] || head_bypass;
    assign head_data   = slot_valid[rd_ptr] ? data_mem[rd_ptr] : rsp_data;

    assign alloc_tag = wr_ptr;
    assign full      = (occupancy == CNT_WIDTH'(QUEUE_SIZE));

    // Control state: pointers, occupancy, per-slot valid bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            slot_valid <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (alloc) begin
                wr_ptr <= wr_ptr + TAG_WIDTH'(1);
            end
            if (drain) begin
                rd_ptr             <= rd_ptr + TAG_WIDTH'(1);
                slot_valid[rd_ptr] <= 1'b0;
            end
            if (rsp_accept && !head_bypass) begin
                slot_valid[rsp_tag] <= 1'b1;
            end
            case ({alloc, drain})
                2'b10:   occupancy <= occupancy + CNT_WIDTH'(1);
                2'b01:   occupancy <= occupancy - CNT_WIDTH'(1);
                default: occupancy <= occupancy;
            endcase
            out_valid <= drain;
        end
    end

    // Data storage carries no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (rsp_accept && !head_bypass) begin
            data_mem[rsp_tag] <= rsp_data;
        end
        if (drain) begin
            out_data <= head_data;
        end
    end

    // A response must target a reserved slot that has not been filled yet.
    always_ff @(posedge clk) begin
        if (reset && rsp_valid) begin
            assert (rsp_allocated && !slot_valid[rsp_tag]);
        end
    end

endmodule

// File: rtl/vx_avs_slave_bridge.sv
// ---------------------------------------------------------------------------
// vx_avs_slave_bridge
//
// Avalon-MM slave front end. Accepts single and burst read/write commands
// and emits one tagged native memory request per beat. Read responses may
// return out of order; vx_avs_rob puts them back into command order before
// they leave on avs_readdata/avs_readdatavalid.
//
// Ports:
//   clk    clock
//   reset  synchronous active-low reset
//   bus    vx_avs_slave_bridge_if.slave
//            avs_*      Avalon-MM slave (command in, waitrequest/readdata out)
//            mem_req_*  per-beat request out (tag = ROB slot for reads)
//            mem_rsp_*  tagged read response in (always ready)
// ---------------------------------------------------------------------------
module vx_avs_slave_bridge
    import vx_avs_slave_bridge_pkg::*;
#(
    parameter int DATA_WIDTH    = 512,
    parameter int ADDR_WIDTH    = 26,
    parameter int BURST_WIDTH   = 4,
    parameter int RD_QUEUE_SIZE = 16
) (
    input logic                  clk,
    input logic                  reset,
    vx_avs_slave_bridge_if.slave bus
);

    localparam int TAG_WIDTH = calc_tag_width(RD_QUEUE_SIZE);

    localparam logic [1:0] STATE_IDLE     = AVS_IDLE;
    localparam logic [1:0] STATE_RD_BURST = AVS_RD_BURST;
    localparam logic [1:0] STATE_WR_BURST = AVS_WR_BURST;

    logic [1:0]              state,      state_n;
    logic [ADDR_WIDTH-1:0]   beat_addr,  beat_addr_n;
    logic [BURST_WIDTH-1:0]  beat_count, beat_count_n;
    logic [BURST_WIDTH-1:0]  burst_len;

    logic                    req_valid;
    logic                    req_rw;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH/8-1:0] req_byteen;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic                    wait_req;

    logic                    rob_alloc;
    logic                    rob_full;
    logic [TAG_WIDTH-1:0]    rob_wr_ptr;

    // A burstcount of zero is a single beat.
    assign burst_len = (bus.avs_burstcount == '0) ? BURST_WIDTH'(1)
                                                  : bus.avs_burstcount;

    // Command FSM and request mux. Reads are only presented to memory when
    // a ROB slot is free, so every issued read owns its tag. Reset forces
    // the bus quiet and stalled regardless of state.
    always_comb begin
        state_n      = state;
        beat_addr_n  = beat_addr;
        beat_count_n = beat_count;
        req_valid    = 1'b0;
        req_rw       = 1'b0;
        req_addr     = beat_addr;
        req_byteen   = '1;
        req_tag      = '0;
        wait_req     = 1'b1;
        rob_alloc    = 1'b0;

        case (state)
            STATE_IDLE: begin
                if (bus.avs_read) begin
                    req_valid = !rob_full;
                    req_addr  = bus.avs_address;
                    req_tag   = rob_wr_ptr;
                    wait_req  = !(bus.mem_req_ready && !rob_full);
                    if (bus.mem_req_ready && !rob_full) begin
                        rob_alloc = 1'b1;
                        if (burst_len > BURST_WIDTH'(1)) begin
                            beat_addr_n  = bus.avs_address + ADDR_WIDTH'(1);
                            beat_count_n = burst_len - BURST_WIDTH'(1);
                            state_n      = STATE_RD_BURST;
                        end
                    end
                end else if (bus.avs_write) begin
                    req_valid  = 1'b1;
                    req_rw     = 1'b1;
                    req_addr   = bus.avs_address;
                    req_byteen = bus.avs_byteenable;
                    wait_req   = !bus.mem_req_ready;
                    if (bus.mem_req_ready && burst_len > BURST_WIDTH'(1)) begin
                        beat_addr_n  = bus.avs_address + ADDR_WIDTH'(1);
                        beat_count_n = burst_len - BURST_WIDTH'(1);
                        state_n      = STATE_WR_BURST;
                    end
                end else begin
                    wait_req = !(bus.mem_req_ready && !rob_full);
                end
            end

            STATE_RD_BURST: begin
                req_valid = !rob_full;
                req_tag   = rob_wr_ptr;
                if (bus.mem_req_ready && !rob_full) begin
                    rob_alloc    = 1'b1;
                    beat_addr_n  = beat_addr + ADDR_WIDTH'(1);
                    beat_count_n = beat_count - BURST_WIDTH'(1);
                    if (beat_count == BURST_WIDTH'(1)) begin
                        state_n = STATE_IDLE;
                    end
                end
            end

            STATE_WR_BURST: begin
                req_valid  = bus.avs_write;
                req_rw     = 1'b1;
                req_byteen = bus.avs_byteenable;
                wait_req   = !bus.mem_req_ready;
                if (bus.avs_write && bus.mem_req_ready) begin
                    beat_addr_n  = beat_addr + ADDR_WIDTH'(1);
                    beat_count_n = beat_count - BURST_WIDTH'(1);
                    if (beat_count == BURST_WIDTH'(1)) begin
                        state_n = STATE_IDLE;
                    end
                end
            end

            default: begin
                state_n = STATE_IDLE;
            end
        endcase

        if (!reset) begin
            req_valid = 1'b0;
            wait_req  = 1'b1;
            rob_alloc = 1'b0;
        end
    end

    // FSM, beat address and remaining-beat registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= STATE_IDLE;
            beat_addr  <= '0;
            beat_count <= '0;
        end else begin
            state      <= state_n;
            beat_addr  <= beat_addr_n;
            beat_count <= beat_count_n;
        end
    end

    vx_avs_rob #(
        .DATA_WIDTH (DATA_WIDTH),
        .QUEUE_SIZE (RD_QUEUE_SIZE),
        .TAG_WIDTH  (TAG_WIDTH)
    ) rob (
        .clk       (clk),
        .reset     (reset),
        .alloc     (rob_alloc),
        .alloc_tag (rob_wr_ptr),
        .full      (rob_full),
        .rsp_valid (bus.mem_rsp_valid),
        .rsp_tag   (bus.mem_rsp_tag),
        .rsp_data  (bus.mem_rsp_data),
        .out_valid (bus.avs_readdatavalid),
        .out_data  (bus.avs_readdata)
    );

    assign bus.avs_waitrequest = wait_req;
    assign bus.mem_req_valid   = req_valid;
    assign bus.mem_req_rw      = req_rw;
    assign bus.mem_req_addr    = req_addr;
    assign bus.mem_req_data    = bus.avs_writedata;
    assign bus.mem_req_byteen  = req_byteen;
    assign bus.mem_req_tag     = req_tag;
    assign bus.mem_rsp_ready   = 1'b1;

endmodule

// File: tb/tb_vx_avs_slave_bridge.sv
// ---------------------------------------------------------------------------
// tb_vx_avs_slave_bridge
//
// Drives Avalon commands and tagged memory responses into the bridge.
// Expected memory requests and expected read beats are queued when the
// stimulus is driven and popped by a monitor when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_vx_avs_slave_bridge;

    localparam int DW  = 64;
    localparam int AW  = 26;
    localparam int BW  = 4;
    localparam int QS  = 16;
    localparam int TW  = 4;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [7:0]    byteen;
        logic [TW-1:0] tag;
    } req_t;

    logic clk;
    logic reset;

    int testsRun;
    int testsFailed;

    req_t          expReq[$];
    logic [DW-1:0] expRd[$];
    logic [AW-1:0] respAddr [QS];
    req_t          monReq;
    logic [DW-1:0] monRd;

    vx_avs_slave_bridge_if #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BURST_WIDTH(BW),
        .TAG_WIDTH  (TW)
    ) bus ();

    vx_avs_slave_bridge #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .BURST_WIDTH  (BW),
        .RD_QUEUE_SIZE(QS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content model: read data is a function of the word address.
    function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
        return {6'h2A, a, 6'h15, ~a};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
                     name, observed, expected, $time);
        end
    endtask

    task automatic pushRead(input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                            input bit expectBeat);
        req_t r;
        r.rw     = 1'b0;
        r.addr   = addr;
        r.data   = '0;
        r.byteen = 8'hFF;
        r.tag    = tag;
        expReq.push_back(r);
        if (expectBeat) expRd.push_back(rdata(addr));
    endtask

    // Issue one read command and hold it until accepted (bounded).
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [BW-1:0] burst);
        bit accepted;
        accepted = 1'b0;
        @(posedge clk); #1;
        bus.avs_read       = 1'b1;
        bus.avs_address    = addr;
        bus.avs_burstcount = burst;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            if (!bus.avs_waitrequest) accepted = 1'b1;
        end
        if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.avs_read = 1'b0;
    endtask

    // One-cycle memory response; optionally require the beat the next cycle.
    task automatic sendResponse(input logic [TW-1:0] tag, input bit checkHead);
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_tag   = tag;
        bus.mem_rsp_data  = rdata(respAddr[tag]);
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b0;
        if (checkHead) begin
            @(negedge clk);
            checkOutput("rd_latency", 64'(bus.avs_readdatavalid), 64'd1);
        end
    endtask

    task automatic waitDrain();
        for (int c = 0; c < 200 && expRd.size() != 0; c++) @(negedge clk);
        checkOutput("drain_timeout", 64'(expRd.size()), 64'd0);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_waitreq",   64'(bus.avs_waitrequest),   64'd1);
        checkOutput("rst_req_valid", 64'(bus.mem_req_valid),     64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_rdvalid",   64'(bus.avs_readdatavalid), 64'd0);
    endtask

    // Monitor: every memory request fire and every read beat is matched
    // against the head of its scoreboard queue.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (expReq.size() == 0) begin
                    checkOutput("req_unexpected", 64'd1, 64'd0);
                end else begin
                    monReq = expReq.pop_front();
                    checkOutput("req_rw",     64'(bus.mem_req_rw),     64'(monReq.rw));
                    checkOutput("req_addr",   64'(bus.mem_req_addr),   64'(monReq.addr));
                    checkOutput("req_tag",    64'(bus.mem_req_tag),    64'(monReq.tag));
                    checkOutput("req_byteen", 64'(bus.mem_req_byteen), 64'(monReq.byteen));
                    if (monReq.rw) begin
                        checkOutput("req_data", bus.mem_req_data, monReq.data);
                    end else begin
                        respAddr[bus.mem_req_tag] = bus.mem_req_addr;
                    end
                end
            end
            if (bus.avs_readdatavalid) begin
                if (expRd.size() == 0) begin
                    checkOutput("rd_unexpected", 64'd1, 64'd0);
                end else begin
                    monRd = expRd.pop_front();
                    checkOutput("rd_data", bus.avs_readdata, monRd);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int            pat [6];
        logic [7:0]    beArr [4];
        int            beat;
        logic [AW-1:0] a;
        req_t          w;

        testsRun    = 0;
        testsFailed = 0;
        for (int i = 0; i < QS; i++) respAddr[i] = '0;

        reset              = 1'b0;
        bus.avs_address    = '0;
        bus.avs_read       = 1'b0;
        bus.avs_write      = 1'b0;
        bus.avs_writedata  = '0;
        bus.avs_byteenable = '0;
        bus.avs_burstcount = '0;
        bus.mem_req_ready  = 1'b1;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = '0;
        bus.mem_rsp_tag    = '0;

        repeat (3) @(posedge clk);
        doReset();

        // Single reads, responses out of order; burstcount 0 acts as 1.
        $display("[TB] single reads");
        for (int i = 0; i < 4; i++) begin
            pushRead(AW'(26'h10 + i), TW'(i), 1'b1);
            applyStimulus(AW'(26'h10 + i), (i == 2) ? 4'd0 : 4'd1);
        end
        sendResponse(4'd3, 1'b0);
        sendResponse(4'd1, 1'b0);
        sendResponse(4'd0, 1'b1);
        sendResponse(4'd2, 1'b1);
        waitDrain();

        // Burst of 8 wrapping the top of the address space.
        $display("[TB] read burst");
        doReset();
        for (int i = 0; i < 8; i++) begin
            a = 26'h3FFFFFE + AW'(i);
            pushRead(a, TW'(i), 1'b1);
        end
        applyStimulus(26'h3FFFFFE, 4'd8);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput("rdburst_waitreq", 64'(bus.avs_waitrequest), 64'd1);
        end
        @(negedge clk);
        checkOutput("rdburst_idle_waitreq", 64'(bus.avs_waitrequest), 64'd0);
        for (int i = 7; i >= 1; i--) sendResponse(TW'(i), 1'b0);
        sendResponse(4'd0, 1'b1);
        waitDrain();

        // Write burst with a stuttering memory ready.
        $display("[TB] write burst");
        pat   = '{1, 0, 1, 1, 0, 1};
        beArr = '{8'hFF, 8'h0F, 8'hF0, 8'h5A};
        for (int j = 0; j < 4; j++) begin
            w.rw     = 1'b1;
            w.addr   = AW'(26'h100 + j);
            w.data   = {32'hC0DE0000 + 32'(j), 32'h12345678 ^ 32'(j)};
            w.byteen = beArr[j];
            w.tag    = '0;
            expReq.push_back(w);
        end
        beat = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            bus.mem_req_ready  = pat[k][0];
            bus.avs_write      = 1'b1;
            bus.avs_burstcount = 4'd4;
            bus.avs_address    = (beat == 0) ? 26'h100 : AW'(26'h2AAA0 + beat);
            bus.avs_writedata  = {32'hC0DE0000 + 32'(beat), 32'h12345678 ^ 32'(beat)};
            bus.avs_byteenable = beArr[beat & 3];
            @(negedge clk);
            if (!bus.avs_waitrequest) beat++;
        end
        @(posedge clk); #1;
        bus.avs_write     = 1'b0;
        bus.mem_req_ready = 1'b1;
        checkOutput("wr_beats", 64'(beat), 64'd4);
        checkOutput("wr_queue_empty", 64'(expReq.size()), 64'd0);

        // Fill the ROB; the 17th read waits for the first drain.
        $display("[TB] rob full");
        doReset();
        for (int i = 0; i < 16; i++) begin
            pushRead(AW'(26'h200 + i), TW'(i), 1'b1);
            applyStimulus(AW'(26'h200 + i), 4'd1);
        end
        pushRead(26'h210, 4'd0, 1'b1);
        @(posedge clk); #1;
        bus.avs_read       = 1'b1;
        bus.avs_address    = 26'h210;
        bus.avs_burstcount = 4'd1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rob_full_stall", 64'(bus.avs_waitrequest), 64'd1);
        end
        sendResponse(4'd0, 1'b1);
        checkOutput("rob_full_accept", 64'(bus.avs_waitrequest), 64'd0);
        @(posedge clk); #1;
        bus.avs_read = 1'b0;
        for (int i = 1; i < 16; i++) sendResponse(TW'(i), 1'b0);
        sendResponse(4'd0, 1'b0);
        waitDrain();

        // Reset during the third beat of a burst-8 read.
        $display("[TB] reset mid-burst");
        pushRead(26'h400, 4'd1, 1'b0);
        pushRead(26'h401, 4'd2, 1'b0);
        @(posedge clk); #1;
        bus.avs_read       = 1'b1;
        bus.avs_address    = 26'h400;
        bus.avs_burstcount = 4'd8;
        @(negedge clk);
        checkOutput("midrst_accept", 64'(bus.avs_waitrequest), 64'd0);
        @(posedge clk); #1;
        bus.avs_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_req_valid", 64'(bus.mem_req_valid),   64'd0);
        checkOutput("midrst_waitreq",   64'(bus.avs_waitrequest), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("postrst_req_valid", 64'(bus.mem_req_valid),   64'd0);
        checkOutput("postrst_idle",      64'(bus.avs_waitrequest), 64'd0);
        checkOutput("postrst_queue",     64'(expReq.size()),       64'd0);
        pushRead(26'h500, 4'd0, 1'b1);
        applyStimulus(26'h500, 4'd1);
        sendResponse(4'd0, 1'b1);
        waitDrain();

        repeat (3) @(posedge clk);
        checkOutput("final_req_queue", 64'(expReq.size()), 64'd0);
        checkOutput("final_rd_queue",  64'(expRd.size()),  64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/vx_avs_slave_bridge.md
# VX_avs_slave_bridge

Avalon-MM slave front end that accepts single and burst read/write commands on an AVS port and converts them into tagged per-beat requests on the native memory request/response interface. It is the responder-side counterpart to the AVS master adapter: it sits between an external Avalon master (host DMA, test harness, or platform shell) and an on-chip memory agent. That agent may return read responses out of order. The block reorders responses so that `avs_readdatavalid` beats leave in command order.

## Interface
- DATA_WIDTH, 512, data bus width in bits (multiple of 8)
- ADDR_WIDTH, 26, word address width
- BURST_WIDTH, 4, `avs_burstcount` width; max burst = 2^(BURST_WIDTH-1)
- RD_QUEUE_SIZE, 16, outstanding read beats (power of 2, ≥2); TAG_WIDTH = CLOG2(RD_QUEUE_SIZE)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- avs_address  in  ADDR_WIDTH  command word address
- avs_read  in  1  read command
- avs_write  in  1  write beat
- avs_writedata  in  DATA_WIDTH  write data
- avs_byteenable  in  DATA_WIDTH/8  write byte mask
- avs_burstcount  in  BURST_WIDTH  beats in command; 0 is treated as 1
- avs_waitrequest  out  1  stall; a command or beat is accepted when it is valid and this is 0
- avs_readdata  out  DATA_WIDTH  read data, registered
- avs_readdatavalid  out  1  read beat valid; no backpressure
- mem_req_valid / mem_req_ready  out / in  1  request handshake
- mem_req_rw  out  1  1 = write
- mem_req_byteen  out  DATA_WIDTH/8  byte mask; all ones for reads
- mem_req_addr  out  ADDR_WIDTH  beat address
- mem_req_data  out  DATA_WIDTH  write data
- mem_req_tag  out  TAG_WIDTH  ROB slot for reads; 0 for writes
- mem_rsp_valid  in  1  response valid
- mem_rsp_data  in  DATA_WIDTH  response data
- mem_rsp_tag  in  TAG_WIDTH  response slot
- mem_rsp_ready  out  1  constant 1, because slots are pre-reserved

## Operation
- FSM states: IDLE, RD_BURST, WR_BURST. Registers: beat address, remaining-beat count.
- **IDLE, read command.** `mem_req_valid` = `avs_read`, address = `avs_address`, tag = ROB write pointer.
  - `avs_waitrequest` = ~(`mem_req_ready` && ROB not full).
  - On acceptance the ROB slot is allocated. If burst > 1, the beat address becomes address+1, the count becomes burst−1, and the FSM goes to RD_BURST.
- **RD_BURST.** `avs_waitrequest` = 1. One beat is issued per cycle while `mem_req_ready` is high and the ROB is not full; each issued beat increments the address and decrements the count. Count reaching 0 returns the FSM to IDLE.
- **IDLE, write.** The first beat is forwarded combinationally and `avs_waitrequest` = ~`mem_req_ready`. If burst > 1, the FSM goes to WR_BURST with address+1 and count burst−1.
- **WR_BURST.** Each `avs_write` beat is forwarded with the internal address; `avs_address` is ignored. `avs_waitrequest` = ~`mem_req_ready`. `avs_read` is ignored until the FSM returns to IDLE.
- `avs_read` and `avs_write` asserted together in IDLE: read wins; `avs_write` is held stalled.
- **ROB.** RD_QUEUE_SIZE data entries with per-slot valid bits, a write (alloc) pointer, a read pointer and an occupancy counter.
  - `mem_rsp_valid` writes `data[tag]` and sets `valid[tag]`.
  - If `valid[rd_ptr]` is set, the next cycle drives `avs_readdatavalid`=1 with that data, clears the bit, and advances rd_ptr.
  - Alloc and drain in the same cycle leave occupancy unchanged. Full when occupancy = RD_QUEUE_SIZE.
- **Arithmetic.**
  - Address increments wrap modulo 2^ADDR_WIDTH.
  - Pointers wrap modulo RD_QUEUE_SIZE.
  - Occupancy is CLOG2(RD_QUEUE_SIZE+1) bits wide.
- **Assertions.** A response to a slot whose valid bit is already set, or to an unallocated slot, is an error.

## Timing
- Request path is combinational in IDLE and WR_BURST: a command accepted at cycle t produces a `mem_req` fire at t. RD_BURST beats fire at t+1 onward.
- Read response: `mem_rsp` at t gives `avs_readdatavalid` at t+1 at the earliest, when the response is for the head slot. Throughput is 1 beat/cycle.
- Reset at 0, sampled on `clk`, in any state:
  - FSM returns to IDLE; pointers, occupancy and valid bits clear.
  - `avs_readdatavalid`=0, `mem_req_valid`=0, `avs_waitrequest`=1.
  - Bursts in flight are dropped, and responses arriving after reset are discarded.

## Structure
- A shared package holds the FSM state enum (`avs_slave_state_t`) and the TAG_WIDTH derivation helper.
- Sub-module `VX_avs_rob`: slot allocation, out-of-order fill and in-order drain. The FSM and request muxing stay in the top module.

## Test plan
- **Single reads.** 4 reads to 0x10–0x13, responses returned in tag order 3,1,0,2 → `avs_readdata` in address order 0x10..0x13, each beat one cycle after its head slot fills.
- **Read burst.** Burst 8 at 0x3FFFFFE (ADDR_WIDTH=26) → mem addrs 0x3FFFFFE, 0x3FFFFFF, 0x0..0x5 with tags 0..7. `avs_waitrequest` stays high until the 8th beat issues.
- **Write burst.** Burst 4 at 0x100 with `mem_req_ready` toggling 1,0,1,1,0,1 → 4 mem writes to 0x100..0x103 with matching data/byteen; `avs_address` on beats 2–4 is ignored.
- **ROB full.** RD_QUEUE_SIZE=16, 17 reads with no responses → 16 accepted, 17th stalls with `avs_waitrequest`=1. The 17th is accepted in the cycle the first beat drains.
- **Reset mid-burst.** `reset`=0 during the 3rd beat of a burst-8 read → next cycle: `mem_req_valid`=0, FSM in IDLE, ROB empty. A new single read then uses tag 0.
